// File: rtl/loader_sender_if.sv
// Bus bundle between loader_sender and its environment: program-start
// request, the byte-memory read port and the uart_tx byte interface.
//   master : the loader_sender side (drives mem_rd_o/mem_addr_o, tx_*_o,
//            busy_o, done_o)
//   slave  : the environment side (drives start_i, base_addr_i, length_i,
//            mem_data_i, tx_busy_i)
interface loader_sender_if #(
  parameter int ADDR_W = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] length_i;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;
  logic [7:0]        tx_byte_o;
  logic              tx_start_o;
  logic              tx_busy_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, base_addr_i, length_i, mem_data_i, tx_busy_i,
    output mem_rd_o, mem_addr_o, tx_byte_o, tx_start_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_addr_i, length_i, mem_data_i, tx_busy_i,
    input  mem_rd_o, mem_addr_o, tx_byte_o, tx_start_o, busy_o, done_o
  );
endinterface

// File: rtl/loader_sender.sv
// loader_sender: streams a program image to a UART transmitter using the
// loader wire protocol: '_' (0x5F), 'p' (0x70), then length bytes read
// sequentially from a byte memory, followed by an idle gap long enough for
// the receiving loader's inactivity timeout to fire.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   bus      loader_sender_if.master: start/base/length request, memory
//            read port (1-cycle latency), uart_tx byte interface, busy/done
module loader_sender #(
  parameter int                ADDR_W     = 16,
  parameter int                GAP_W      = 26,
  parameter logic [GAP_W-1:0]  GAP_CYCLES = 26'h30E_3600
) (
  input  logic            clk_i,
  input  logic            reset_i,
  loader_sender_if.master bus
);

  localparam logic [7:0]       PRE0_BYTE = 8'h5F;
  localparam logic [7:0]       PRE1_BYTE = 8'h70;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_CYCLES - 1'b1;

  typedef enum logic [2:0] {
    IDLE, PRE0, PRE1, FETCH, LATCH, SEND, TXWAIT, GAP
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q;      // where TXWAIT goes once the byte is out
  logic              first_q;    // first TXWAIT cycle: tx_busy_i not yet valid
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [GAP_W-1:0]  gap_q;
  logic [7:0]        tx_byte_q;

  // A byte may only be handed over while the transmitter is free.
  logic tx_go;
  assign tx_go = !bus.tx_busy_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:             if (bus.start_i) state_d = PRE0;
      PRE0, PRE1, SEND: if (tx_go) state_d = TXWAIT;
      FETCH:            state_d = LATCH;
      LATCH:            state_d = SEND;
      // tx_busy_i only rises the cycle after tx_start_o, so the first
      // TXWAIT cycle would see a stale low.
      TXWAIT:           if (!first_q && tx_go) state_d = ret_q;
      GAP:              if (gap_q == GAP_LAST) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.tx_start_o = 1'b0;
    bus.mem_rd_o   = 1'b0;
    bus.done_o     = 1'b0;
    bus.busy_o     = (state_q != IDLE);
    bus.mem_addr_o = addr_q;
    bus.tx_byte_o  = tx_byte_q;
    unique case (state_q)
      PRE0, PRE1, SEND: bus.tx_start_o = tx_go;
      FETCH:            bus.mem_rd_o   = 1'b1;
      GAP:              bus.done_o     = (gap_q == GAP_LAST);
      default: ;
    endcase
  end

  // Datapath: address/count, byte holding register, return target, gap timer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ret_q     <= IDLE;
      first_q   <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      tx_byte_q <= '0;
    end else begin
      first_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.start_i) begin
          addr_q    <= bus.base_addr_i;
          rem_q     <= bus.length_i;
          tx_byte_q <= PRE0_BYTE;
        end
        PRE0: if (tx_go) begin
          ret_q   <= PRE1;
          first_q <= 1'b1;
        end
        PRE1: if (tx_go) begin
          ret_q   <= (rem_q == '0) ? GAP : FETCH;
          first_q <= 1'b1;
        end
        LATCH: begin
          tx_byte_q <= bus.mem_data_i;
          addr_q    <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
          rem_q     <= rem_q - 1'b1;
        end
        SEND: if (tx_go) begin
          ret_q   <= (rem_q != '0) ? FETCH : GAP;
          first_q <= 1'b1;
        end
        // '_' must stay on tx_byte_o until its transmission is finished,
        // so 'p' is loaded only on the way back into PRE1.
        TXWAIT: if (!first_q && tx_go && ret_q == PRE1) tx_byte_q <= PRE1_BYTE;
        default: ;
      endcase
      // Counts cycles spent in GAP; zero on entry.
      gap_q <= (state_q == GAP && state_d == GAP) ? gap_q + 1'b1 : '0;
    end
  end

endmodule
